// File: rtl/fib_seq_gen.sv
// Fibonacci word source with a valid/ready output: emits F(0), F(1), ... and
// stops after the largest Fibonacci number that fits in WIDTH bits.
module fib_seq_gen #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   b_q;
    logic [CNT_W-1:0] count_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             busy_q;
    logic             done_q;

    logic             fire;
    logic [WIDTH:0]   sum_d;
    logic [CNT_W-1:0] count_d;

    assign fire    = out_valid_q & out_ready;
    assign sum_d   = a_q + b_q;
    assign count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= (WIDTH+1)'(1);
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        a_q         <= '0;
                        b_q         <= (WIDTH+1)'(1);
                        count_q     <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                RUN: begin
                    if (fire) begin
                        count_q <= count_d;
                        // b spilling into bit WIDTH means the word on the bus is the last one
                        if (b_q[WIDTH]) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            a_q        <= b_q;
                            b_q        <= sum_d;
                            out_data_q <= b_q[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: WIDTH=4 and WIDTH=8 instances checked
// against a plain-arithmetic Fibonacci reference.
module tb_fib_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, rdy4, v4, busy4, done4;
    logic [3:0] d4;
    logic [7:0] count4;
    logic       start8, rdy8, v8, busy8, done8;
    logic [7:0] d8;
    logic [7:0] count8;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned q4[$];
    int unsigned q8[$];

    always #5 clk = ~clk;

    fib_seq_gen #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .out_ready(rdy4),
        .out_valid(v4), .out_data(d4), .busy(busy4), .done(done4), .count(count4)
    );

    fib_seq_gen #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .out_ready(rdy8),
        .out_valid(v8), .out_data(d8), .busy(busy8), .done(done8), .count(count8)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every Fibonacci number below 2^w, duplicates included.
    task automatic push_exp(input int unsigned w, input bit wide, output int unsigned n);
        longint unsigned x = 0, y = 1, t;
        n = 0;
        while (x < (64'd1 << w)) begin
            if (wide) q8.push_back(int'(x));
            else      q4.push_back(int'(x));
            n++;
            t = x + y;
            x = y;
            y = t;
        end
    endtask

    bit         stall4 = 0, stall8 = 0;
    logic [3:0] sd4;
    logic [7:0] sc4;
    logic [7:0] sd8;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall4 = 0;
        end else begin
            if (!v4) check("gate4", d4, 0);
            if (stall4) begin
                check("hold_valid4", v4, 1);
                check("hold_data4", d4, sd4);
                check("hold_count4", count4, sc4);
            end
            if (v4 && rdy4) begin
                if (q4.size() == 0) check("extra_word4", d4, 1000);
                else check("word4", d4, q4.pop_front());
            end
            stall4 = v4 && !rdy4;
            sd4    = d4;
            sc4    = count4;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall8 = 0;
        end else begin
            if (!v8) check("gate8", d8, 0);
            if (stall8) begin
                check("hold_valid8", v8, 1);
                check("hold_data8", d8, sd8);
            end
            if (v8 && rdy8) begin
                if (q8.size() == 0) check("extra_word8", d8, 1000);
                else check("word8", d8, q8.pop_front());
            end
            stall8 = v8 && !rdy8;
            sd8    = d8;
        end
    end

    task automatic start_seq4();
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("start_valid4", v4, 1);
        check("start_data4", d4, 0);
        check("start_busy4", busy4, 1);
        check("start_done4", done4, 0);
        check("start_count4", count4, 0);
    endtask

    // mode 0: ready=1, 1: fixed pattern, 2: random; poke pulses start while word 3 is shown
    task automatic run_seq4(input int mode, input int unsigned exp_n, input bit poke);
        int unsigned cyc = 0;
        bit pat[6] = '{1, 0, 0, 1, 0, 1};
        while (!done4 && cyc < 300) begin
            case (mode)
                0:       rdy4 = 1'b1;
                1:       rdy4 = pat[cyc % 6];
                default: rdy4 = 1'($urandom_range(0, 1));
            endcase
            if (poke && v4 && d4 == 4'd3) start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            cyc++;
        end
        rdy4 = 1'b1;
        check("done_reached4", done4, 1);
        check("final_count4", count4, exp_n);
        check("final_valid4", v4, 0);
        check("final_busy4", busy4, 0);
        check("queue_drained4", q4.size(), 0);
    endtask

    initial begin
        int unsigned n;
        int unsigned cyc;
        rst_n = 1'b0; start4 = 1'b0; rdy4 = 1'b1; start8 = 1'b0; rdy8 = 1'b1;
        #3;
        check("rst_valid4", v4, 0); check("rst_data4", d4, 0);
        check("rst_busy4", busy4, 0); check("rst_done4", done4, 0);
        check("rst_count4", count4, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_valid4", v4, 0); check("idle_busy4", busy4, 0);
        check("idle_done4", done4, 0); check("idle_count4", count4, 0);

        // Full sweep with exact cycle timing
        push_exp(4, 1'b0, n);
        start_seq4();
        repeat (7) begin
            @(posedge clk); #1;
            check("sweep_not_done4", done4, 0);
            check("sweep_valid4", v4, 1);
        end
        @(posedge clk); #1;
        check("sweep_done4", done4, 1);
        run_seq4(0, 8, 1'b0);

        // Backpressure pattern, then random ready
        push_exp(4, 1'b0, n);
        start_seq4();
        run_seq4(1, 8, 1'b0);
        push_exp(4, 1'b0, n);
        start_seq4();
        run_seq4(2, 8, 1'b0);

        // start while busy is ignored; restart from DONE
        push_exp(4, 1'b0, n);
        start_seq4();
        run_seq4(0, 8, 1'b1);

        // Asynchronous reset after word 5 is accepted
        push_exp(4, 1'b0, n);
        start_seq4();
        cyc = 0;
        while (!(v4 && d4 == 4'd8) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_word8", d4, 8);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid4", v4, 0); check("async_data4", d4, 0);
        check("async_busy4", busy4, 0); check("async_done4", done4, 0);
        check("async_count4", count4, 0);
        q4.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy4", busy4, 0); check("post_rst_count4", count4, 0);
        push_exp(4, 1'b0, n);
        start_seq4();
        run_seq4(2, 8, 1'b0);

        // WIDTH=8: ends at 233 after 14 words
        push_exp(8, 1'b1, n);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("start_valid8", v8, 1);
        check("start_data8", d8, 0);
        cyc = 0;
        while (!done8 && cyc < 500) begin
            rdy8 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        rdy8 = 1'b1;
        check("done_reached8", done8, 1);
        check("final_count8", count8, 14);
        check("final_valid8", v8, 0);
        check("queue_drained8", q8.size(), 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
